// File: rtl/pcie_tx_scrambler_if.sv
// -----------------------------------------------------------------------------
// pcie_tx_scrambler_pkg / pcie_tx_scrambler_if
//
// Shared types and the beat bus of the PCIe lane transmit scrambler.
//
// Package:
//   rate_speed_e : PIPE data rate encoding (GEN1..GEN5).
//
// Interface signals (one lane, 32-bit beat, byte 0 = bits [7:0] sent first):
//   data_valid_i   beat valid
//   data_in_i      unscrambled symbols
//   data_k_in_i    per-byte K flag (Gen1/Gen2)
//   sync_header_i  Gen3 sync header, meaningful on block_start_i beats
//   block_start_i  first beat of a Gen3 128-bit block
//   data_valid_o   registered data_valid_i
//   data_out_o     scrambled symbols
//   data_k_out_o   registered data_k_in_i
//   sync_header_o  registered sync_header_i
//   block_start_o  registered block_start_i
//
// Handshake: data_valid_i qualifies a beat and there is no ready; every
// valid beat is accepted on the clock edge where it is sampled, and the
// matching result is presented with data_valid_o exactly one cycle later.
//
// Modports:
//   slave  : the scrambler (consumes *_i, produces *_o)
//   master : the upstream mux / checker side
// -----------------------------------------------------------------------------
package pcie_tx_scrambler_pkg;

    typedef enum logic [2:0] {
        GEN1 = 3'd0,
        GEN2 = 3'd1,
        GEN3 = 3'd2,
        GEN4 = 3'd3,
        GEN5 = 3'd4
    } rate_speed_e;

endpackage

interface pcie_tx_scrambler_if;

    logic        data_valid_i;
    logic [31:0] data_in_i;
    logic [3:0]  data_k_in_i;
    logic [1:0]  sync_header_i;
    logic        block_start_i;

    logic        data_valid_o;
    logic [31:0] data_out_o;
    logic [3:0]  data_k_out_o;
    logic [1:0]  sync_header_o;
    logic        block_start_o;

    modport slave (
        input  data_valid_i,
        input  data_in_i,
        input  data_k_in_i,
        input  sync_header_i,
        input  block_start_i,
        output data_valid_o,
        output data_out_o,
        output data_k_out_o,
        output sync_header_o,
        output block_start_o
    );

    modport master (
        output data_valid_i,
        output data_in_i,
        output data_k_in_i,
        output sync_header_i,
        output block_start_i,
        input  data_valid_o,
        input  data_out_o,
        input  data_k_out_o,
        input  sync_header_o,
        input  block_start_o
    );

endinterface

// File: rtl/pcie_tx_scrambler.sv
// -----------------------------------------------------------------------------
// pcie_tx_scrambler
//
// Transmit-side scrambler for one PCIe lane. Gen1/Gen2 use the 16-bit
// 8b/10b-era LFSR with COM/SKP rules; Gen3 and above use the 23-bit per-lane
// LFSR with 128b/130b block rules (data blocks scrambled, ordered sets not,
// SKP OS freezes the LFSR, EIEOS reloads the lane seed at block end).
// One-cycle registered latency, one beat per cycle, no backpressure.
//
// Ports:
//   clk_i               PHY transmit clock
//   rst_ni              asynchronous active-low reset
//   lane_number_i       logical lane; bits [2:0] pick the Gen3 seed
//   curr_data_rate_i    current rate (rate_speed_e)
//   pipe_width_i        valid bits per beat: 8, 16 or 32 (others act as 32)
//   scramble_disable_i  Gen1/Gen2 scramble bypass for D symbols
//   bus                 beat bus (pcie_tx_scrambler_if.slave)
// -----------------------------------------------------------------------------
module pcie_tx_scrambler
    import pcie_tx_scrambler_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [7:0]         lane_number_i,
    input  rate_speed_e        curr_data_rate_i,
    input  logic [5:0]         pipe_width_i,
    input  logic               scramble_disable_i,
    pcie_tx_scrambler_if.slave bus
);

    localparam logic [15:0] G1_SEED  = 16'hFFFF;
    // Feedback taps for X^5+X^4+X^3+1 in a left-shifting Galois LFSR.
    localparam logic [15:0] G1_TAPS  = 16'h0039;
    // Feedback taps for X^21+X^16+X^8+X^5+X^2+1.
    localparam logic [22:0] G3_TAPS  = 23'h210125;
    localparam logic [7:0]  K_COM    = 8'hBC;
    localparam logic [7:0]  K_SKP    = 8'h1C;
    localparam logic [7:0]  OS_SKP   = 8'hAA;
    localparam logic [7:0]  OS_EIEOS = 8'h00;

    // Kind of the Gen3 block in flight; ordered-set subtypes decide how the
    // LFSR moves while the bytes themselves always pass unscrambled.
    typedef enum logic [1:0] {
        BLK_OS_OTHER = 2'd0,
        BLK_OS_SKP   = 2'd1,
        BLK_OS_EIEOS = 2'd2,
        BLK_DATA     = 2'd3
    } blk_e;

    // -------------------------------------------------------------------------
    // LFSR helpers. Each returns {next_state, key_byte}; key bit i is the LFSR
    // MSB before the i-th shift, so bit 0 of the key lines up with the first
    // transmitted bit of the byte.
    // -------------------------------------------------------------------------
    function automatic logic [23:0] g1_step(input logic [15:0] s);
        logic [15:0] t;
        logic [7:0]  k;
        t = s;
        k = 8'h00;
        for (int i = 0; i < 8; i++) begin
            k[i] = t[15];
            t    = {t[14:0], 1'b0} ^ (t[15] ? G1_TAPS : 16'h0000);
        end
        return {t, k};
    endfunction

    function automatic logic [30:0] g3_step(input logic [22:0] s);
        logic [22:0] t;
        logic [7:0]  k;
        t = s;
        k = 8'h00;
        for (int i = 0; i < 8; i++) begin
            k[i] = t[22];
            t    = {t[21:0], 1'b0} ^ (t[22] ? G3_TAPS : 23'h000000);
        end
        return {t, k};
    endfunction

    function automatic logic [22:0] g3_seed(input logic [2:0] lane);
        logic [22:0] s;
        case (lane)
            3'd0:    s = 23'h1DBFBC;
            3'd1:    s = 23'h0607BB;
            3'd2:    s = 23'h1EC760;
            3'd3:    s = 23'h18C0DB;
            3'd4:    s = 23'h010F12;
            3'd5:    s = 23'h19CFC9;
            3'd6:    s = 23'h0277CE;
            default: s = 23'h1BB807;
        endcase
        return s;
    endfunction

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [15:0] lfsr1_q;
    logic [22:0] lfsr3_q;
    // While set, the Gen3 LFSR is taken as the seed of the *current* lane
    // number instead of lfsr3_q. This lets reset and rate-change reloads
    // follow lane_number_i without a data-dependent reset value.
    logic        lfsr3_fresh_q;
    logic [3:0]  cnt_q;
    blk_e        blk_q;
    logic        prev_gen3_q;
    // Rate history is only meaningful after the first clock out of reset.
    logic        rate_tracked_q;

    // -------------------------------------------------------------------------
    // Combinational beat processing
    // -------------------------------------------------------------------------
    logic        is_gen3;
    logic        rate_flip;
    logic [22:0] seed3;
    int          nbytes;
    logic [15:0] l1;
    logic [22:0] l3;
    logic [3:0]  cnt;
    blk_e        blk;
    logic [31:0] dout;
    logic [7:0]  din_b;
    logic [23:0] step1;
    logic [30:0] step3;
    logic        unused_lane_bits;

    assign unused_lane_bits = ^lane_number_i[7:3];

    always_comb begin
        is_gen3   = (curr_data_rate_i >= GEN3);
        rate_flip = rate_tracked_q && (is_gen3 != prev_gen3_q);
        seed3     = g3_seed(lane_number_i[2:0]);

        case (pipe_width_i)
            6'd8:    nbytes = 1;
            6'd16:   nbytes = 2;
            default: nbytes = 4;
        endcase

        l1    = lfsr1_q;
        l3    = lfsr3_fresh_q ? seed3 : lfsr3_q;
        cnt   = cnt_q;
        blk   = blk_q;
        dout  = bus.data_in_i;
        din_b = 8'h00;
        step1 = 24'h000000;
        step3 = 31'h00000000;

        // A block start decides the block kind from its own header and first
        // byte, so those bytes are handled correctly within the same beat.
        if (bus.data_valid_i && bus.block_start_i && is_gen3) begin
            cnt = 4'd0;
            if (bus.sync_header_i == 2'b10) begin
                blk = BLK_DATA;
            end else if (bus.data_in_i[7:0] == OS_SKP) begin
                blk = BLK_OS_SKP;
            end else if (bus.data_in_i[7:0] == OS_EIEOS) begin
                blk = BLK_OS_EIEOS;
            end else begin
                blk = BLK_OS_OTHER;
            end
        end

        for (int s = 0; s < 4; s++) begin
            if (s < nbytes) begin
                din_b = bus.data_in_i[8*s +: 8];
                if (!is_gen3) begin
                    step1 = g1_step(l1);
                    if (bus.data_k_in_i[s]) begin
                        if (din_b == K_COM) begin
                            l1 = G1_SEED;
                        end else if (din_b != K_SKP) begin
                            l1 = step1[23:8];
                        end
                    end else begin
                        if (!scramble_disable_i) begin
                            dout[8*s +: 8] = din_b ^ step1[7:0];
                        end
                        l1 = step1[23:8];
                    end
                end else begin
                    step3 = g3_step(l3);
                    if (blk == BLK_DATA) begin
                        dout[8*s +: 8] = din_b ^ step3[7:0];
                        l3 = step3[30:8];
                    end else if (blk != BLK_OS_SKP) begin
                        l3 = step3[30:8];
                        if (blk == BLK_OS_EIEOS && cnt == 4'd15) begin
                            l3 = seed3;
                        end
                    end
                    cnt = cnt + 4'd1;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bus.data_valid_o  <= 1'b0;
            bus.data_out_o    <= 32'h0;
            bus.data_k_out_o  <= 4'h0;
            bus.sync_header_o <= 2'b00;
            bus.block_start_o <= 1'b0;
            lfsr1_q           <= G1_SEED;
            lfsr3_q           <= 23'h000000;
            lfsr3_fresh_q     <= 1'b1;
            cnt_q             <= 4'd0;
            blk_q             <= BLK_OS_OTHER;
            prev_gen3_q       <= 1'b0;
            rate_tracked_q    <= 1'b0;
        end else begin
            bus.data_valid_o  <= bus.data_valid_i;
            bus.data_out_o    <= bus.data_valid_i ? dout : bus.data_in_i;
            bus.data_k_out_o  <= bus.data_k_in_i;
            bus.sync_header_o <= bus.sync_header_i;
            bus.block_start_o <= bus.block_start_i;
            rate_tracked_q    <= 1'b1;
            prev_gen3_q       <= is_gen3;

            // Crossing the Gen3 boundary wins over any beat in the same
            // cycle: both scramblers restart from seed for the next beat.
            if (rate_flip) begin
                lfsr1_q       <= G1_SEED;
                lfsr3_fresh_q <= 1'b1;
                cnt_q         <= 4'd0;
            end else if (bus.data_valid_i) begin
                if (is_gen3) begin
                    lfsr3_q       <= l3;
                    lfsr3_fresh_q <= 1'b0;
                    cnt_q         <= cnt;
                    blk_q         <= blk;
                end else begin
                    lfsr1_q <= l1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pcie_tx_scrambler.sv
// -----------------------------------------------------------------------------
// tb_pcie_tx_scrambler
//
// Directed bench for pcie_tx_scrambler. Gen1/Gen2 expectations come from the
// hand-listed key bytes; Gen3 expectations come from a bit-serial key stream
// computed here from each lane seed, indexed by hand per block.
// -----------------------------------------------------------------------------
module tb_pcie_tx_scrambler;
    import pcie_tx_scrambler_pkg::*;

    // ---------------- clock / reset ----------------
    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic [7:0]  lane_number = 8'd0;
    rate_speed_e curr_rate = GEN1;
    logic [5:0]  pipe_width = 6'd32;
    logic        scr_dis = 1'b0;

    always #5 clk_i = ~clk_i;

    pcie_tx_scrambler_if bus();

    pcie_tx_scrambler dut (
        .clk_i              (clk_i),
        .rst_ni             (rst_ni),
        .lane_number_i      (lane_number),
        .curr_data_rate_i   (curr_rate),
        .pipe_width_i       (pipe_width),
        .scramble_disable_i (scr_dis),
        .bus                (bus)
    );

    // ---------------- scoreboard state ----------------
    logic [38:0] exp_q[$];
    int          total = 0;
    int          bad = 0;
    string       phase = "init";
    logic [38:0] mon_got;
    logic [38:0] mon_exp;

    // Scrambler key bytes after COM for an all-zero D stream.
    logic [7:0] g1_exp [16] = '{8'hBC, 8'hFF, 8'h17, 8'hC0, 8'h14, 8'hB2, 8'hE7, 8'h02,
                                8'h82, 8'h72, 8'h6E, 8'h28, 8'hA6, 8'hBE, 8'h6D, 8'hBF};
    logic [7:0] ks [64];

    // Gen3 key stream from a lane seed, one bit at a time.
    task automatic fill_ks(input logic [2:0] lane);
        logic [22:0] s;
        case (lane)
            3'd0: s = 23'h1DBFBC;
            3'd1: s = 23'h0607BB;
            3'd2: s = 23'h1EC760;
            3'd3: s = 23'h18C0DB;
            3'd4: s = 23'h010F12;
            3'd5: s = 23'h19CFC9;
            3'd6: s = 23'h0277CE;
            default: s = 23'h1BB807;
        endcase
        for (int n = 0; n < 64; n++) begin
            for (int i = 0; i < 8; i++) begin
                ks[n][i] = s[22];
                if (s[22]) s = {s[21:0], 1'b0} ^ 23'h210125;
                else       s = {s[21:0], 1'b0};
            end
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk_i) begin
        if (rst_ni && bus.data_valid_o) begin
            mon_got = {bus.data_k_out_o, bus.sync_header_o, bus.block_start_o, bus.data_out_o};
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL %s unexpected_beat got=%h required=none", phase, mon_got);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_got !== mon_exp) begin
                    bad++;
                    $display("FAIL %s beat got=%h required=%h", phase, mon_got, mon_exp);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic [31:0] din, input logic [3:0] kin, input logic [1:0] sh,
                        input logic bs, input logic [31:0] dexp);
        @(posedge clk_i);
        #1;
        bus.data_valid_i  = 1'b1;
        bus.data_in_i     = din;
        bus.data_k_in_i   = kin;
        bus.sync_header_i = sh;
        bus.block_start_i = bs;
        exp_q.push_back({kin, sh, bs, dexp});
    endtask

    task automatic idle();
        @(posedge clk_i);
        #1;
        bus.data_valid_i  = 1'b0;
        bus.data_in_i     = 32'h0;
        bus.data_k_in_i   = 4'h0;
        bus.sync_header_i = 2'b00;
        bus.block_start_i = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        logic [39:0] got;
        got = {bus.data_valid_o, bus.data_k_out_o, bus.sync_header_o, bus.block_start_o,
               bus.data_out_o};
        total++;
        if (got !== 40'h0) begin
            bad++;
            $display("FAIL %s outputs_in_reset got=%h required=0", tag, got);
        end
    endtask

    task automatic do_reset(input logic [2:0] lane, input rate_speed_e rate, input string tag);
        idle();
        @(negedge clk_i);
        #2;
        rst_ni            = 1'b0;
        lane_number       = {5'd0, lane};
        curr_rate         = rate;
        bus.data_valid_i  = 1'b1;
        bus.data_in_i     = 32'hDEADBEEF;
        bus.data_k_in_i   = 4'hF;
        bus.sync_header_i = 2'b10;
        bus.block_start_i = 1'b1;
        #1;
        check_zero(tag);
        @(negedge clk_i);
        check_zero(tag);
        @(posedge clk_i);
        #1;
        rst_ni            = 1'b1;
        bus.data_valid_i  = 1'b0;
        bus.data_in_i     = 32'h0;
        bus.data_k_in_i   = 4'h0;
        bus.sync_header_i = 2'b00;
        bus.block_start_i = 1'b0;
    endtask

    // COM followed by 15 D 0x00 at the current width; unused slots carry a
    // fixed pad that must come out untouched.
    task automatic gen1_stream();
        int nb;
        nb = int'(pipe_width) / 8;
        for (int b = 0; b < 16 / nb; b++) begin
            logic [31:0] din;
            logic [31:0] dexp;
            logic [3:0]  kin;
            kin = 4'h0;
            for (int j = 0; j < 4; j++) begin
                if (j < nb) begin
                    din[8*j +: 8]  = (b * nb + j == 0) ? 8'hBC : 8'h00;
                    dexp[8*j +: 8] = g1_exp[b * nb + j];
                    kin[j]         = (b * nb + j == 0);
                end else begin
                    din[8*j +: 8]  = (j == 2) ? 8'h5A : 8'h00;
                    dexp[8*j +: 8] = din[8*j +: 8];
                end
            end
            send(din, kin, 2'b00, 1'b0, dexp);
        end
    endtask

    // Gen3 data block at width 32 using keys ks[kbase +: 16].
    task automatic g3_data_block(input int kbase, input int nbeats, input logic zero_data);
        for (int b = 0; b < nbeats; b++) begin
            logic [31:0] din;
            logic [31:0] dexp;
            for (int j = 0; j < 4; j++) begin
                logic [7:0] v;
                v = zero_data ? 8'h00 : 8'((b * 4 + j) * 37 + 5);
                din[8*j +: 8]  = v;
                dexp[8*j +: 8] = v ^ ks[kbase + b * 4 + j];
            end
            send(din, 4'h0, (b == 0) ? 2'b10 : 2'b00, (b == 0), dexp);
        end
    endtask

    // Gen3 ordered-set block; bytes must pass unchanged.
    task automatic g3_os_block(input logic [7:0] first);
        for (int b = 0; b < 4; b++) begin
            logic [31:0] din;
            for (int j = 0; j < 4; j++) begin
                din[8*j +: 8] = (b == 0 && j == 0) ? first : 8'(8'hF0 ^ (b * 4 + j));
            end
            send(din, 4'h0, (b == 0) ? 2'b01 : 2'b00, (b == 0), din);
        end
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        bus.data_valid_i  = 1'b0;
        bus.data_in_i     = 32'h0;
        bus.data_k_in_i   = 4'h0;
        bus.sync_header_i = 2'b00;
        bus.block_start_i = 1'b0;

        phase = "reset";
        do_reset(3'd0, GEN1, "reset");

        phase = "gen1_w32";
        pipe_width = 6'd32;
        gen1_stream();

        phase = "gen1_skp";
        send(32'h1C1C00BC, 4'b1101, 2'b00, 1'b0, 32'h1C1CFFBC);
        send(32'h00BC001C, 4'b0101, 2'b00, 1'b0, 32'hFFBC171C);
        idle();
        phase = "gen1_disable";
        scr_dis = 1'b1;
        send(32'h1C1C00BC, 4'b1101, 2'b00, 1'b0, 32'h1C1C00BC);
        send(32'h00BC001C, 4'b0101, 2'b00, 1'b0, 32'h00BC001C);
        idle();
        scr_dis = 1'b0;
        send(32'h00000000, 4'b0000, 2'b00, 1'b0, 32'hB214C017);

        idle();
        phase = "gen1_w8";
        pipe_width = 6'd8;
        gen1_stream();
        idle();
        phase = "gen1_w16";
        pipe_width = 6'd16;
        gen1_stream();
        idle();
        pipe_width = 6'd32;

        for (int lane = 0; lane < 8; lane++) begin
            phase = $sformatf("gen3_lane%0d", lane);
            do_reset(3'(lane), GEN3, phase);
            fill_ks(3'(lane));
            g3_data_block(0, 4, 1'b1);
        end

        phase = "gen3_os";
        do_reset(3'd5, GEN3, phase);
        fill_ks(3'd5);
        g3_data_block(0, 4, 1'b0);
        g3_os_block(8'h00);
        g3_data_block(0, 4, 1'b0);
        g3_data_block(16, 4, 1'b0);
        g3_os_block(8'hAA);
        g3_data_block(32, 4, 1'b0);

        phase = "rate_change";
        idle();
        curr_rate = GEN2;
        send(32'h00000000, 4'b0000, 2'b00, 1'b0, 32'h14C017FF);
        send(32'h00000000, 4'b0000, 2'b00, 1'b0, 32'h8202E7B2);
        idle();
        curr_rate = GEN3;
        g3_data_block(0, 4, 1'b1);
        idle();
        curr_rate = GEN2;
        send(32'h00000000, 4'b0000, 2'b00, 1'b0, 32'h14C017FF);

        phase = "reset_mid_block";
        do_reset(3'd2, GEN3, phase);
        fill_ks(3'd2);
        g3_data_block(0, 2, 1'b0);
        do_reset(3'd2, GEN3, phase);
        g3_data_block(0, 4, 1'b0);

        phase = "drain";
        idle();
        repeat (3) @(posedge clk_i);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain pending_beats got=%0d required=0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
